ysyx_mem_arbiter: RTL and testbench

//  Shares the single memory bus between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).

---
 rtl/ysyx_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_mem_arbiter.sv
// Serialises IFU and LSU accesses onto one memory bus, with hung-access timeout.
// Define YSYX_ARB_RR_EN for round-robin tie-breaking; otherwise LSU wins ties.
module ysyx_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rvalid,
  output logic                lsu_bvalid,
  output logic                rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata
);

  localparam int unsigned      STRB_W   = DATA_W / 8;
  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic             OWN_IFU  = 1'b0;
  localparam logic             OWN_LSU  = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t           state, state_nx;
  logic             owner, owner_nx;
  logic             is_write, is_write_nx;
  logic             orphan, orphan_nx;
  logic             last_owner, last_owner_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             done, err;
  logic             lsu_req, grant_lsu, tmo_hit, rsp_hit, in_req, req_wr;

  assign lsu_req = lsu_arvalid | lsu_awvalid;
  assign tmo_hit = TMO_EN & (timer >= TMO_LAST);
  // A response that belongs to an abandoned access is swallowed, not routed.
  assign rsp_hit = mem_rsp_valid & ~orphan;

`ifdef YSYX_ARB_RR_EN
  assign grant_lsu = lsu_req & (~ifu_arvalid | (last_owner == OWN_IFU));
`else
  assign grant_lsu = lsu_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_LSU;
      is_write   <= 1'b0;
      timer      <= '0;
      orphan     <= 1'b0;
      last_owner <= OWN_LSU;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      is_write   <= is_write_nx;
      timer      <= timer_nx;
      orphan     <= orphan_nx;
      last_owner <= last_owner_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    is_write_nx   = is_write;
    timer_nx      = timer;
    orphan_nx     = orphan & ~mem_rsp_valid;
    last_owner_nx = last_owner;
    done          = 1'b0;
    err           = 1'b0;
    case (state)
      IDLE: begin
        if (lsu_req | ifu_arvalid) begin
          state_nx    = REQ;
          timer_nx    = '0;
          owner_nx    = grant_lsu ? OWN_LSU : OWN_IFU;
          is_write_nx = grant_lsu & lsu_awvalid;
        end
      end
      REQ: begin
        timer_nx = timer + CNT_W'(1);
        if (mem_req_ready) begin
          state_nx = RSP;
        end else if (tmo_hit) begin
          done     = 1'b1;
          err      = 1'b1;
          state_nx = IDLE;
        end
      end
      RSP: begin
        timer_nx = timer + CNT_W'(1);
        if (rsp_hit) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (tmo_hit) begin
          done      = 1'b1;
          err       = 1'b1;
          orphan_nx = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (done) last_owner_nx = owner;
  end

  // Request fields follow the owner's held inputs while in REQ, zero otherwise.
  assign in_req        = (state == REQ);
  assign req_wr        = in_req & is_write;
  assign mem_req_valid = in_req;
  assign mem_req_we    = req_wr;
  assign mem_req_addr  = !in_req             ? '0 :
                         (owner == OWN_IFU)  ? ifu_araddr :
                         is_write            ? lsu_awaddr : lsu_araddr;
  assign mem_req_wdata = req_wr ? lsu_wdata : '0;
  assign mem_req_wstrb = req_wr ? lsu_wstrb : STRB_W'(0);

  assign ifu_rvalid = done & (owner == OWN_IFU);
  assign lsu_rvalid = done & (owner == OWN_LSU) & ~is_write;
  assign lsu_bvalid = done & (owner == OWN_LSU) & is_write;
  assign rsp_err    = err;
  assign ifu_rdata  = (ifu_rvalid & ~err) ? mem_rsp_rdata : '0;
  assign lsu_rdata  = (lsu_rvalid & ~err) ? mem_rsp_rdata : '0;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// Directed bench for ysyx_mem_arbiter with a completion scoreboard.
// Expected grant order follows YSYX_ARB_RR_EN when it is defined.
module tb_ysyx_mem_arbiter;

  logic        clk, rst;
  logic [31:0] ifu_araddr, ifu_rdata;
  logic        ifu_arvalid, ifu_rvalid;
  logic [31:0] lsu_araddr, lsu_awaddr, lsu_wdata, lsu_rdata;
  logic        lsu_arvalid, lsu_awvalid, lsu_rvalid, lsu_bvalid;
  logic [3:0]  lsu_wstrb, mem_req_wstrb;
  logic        rsp_err, mem_req_valid, mem_req_ready, mem_req_we, mem_rsp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;

  ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
    .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid), .lsu_bvalid(lsu_bvalid),
    .rsp_err(rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  typedef struct {
    logic [2:0]  kind;   // {ifu_rvalid, lsu_rvalid, lsu_bvalid}
    logic [63:0] data;   // {ifu_rdata, lsu_rdata}
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   waited;
  int   k;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] kind, input logic [31:0] d, input logic e);
    exp_t x;
    x.kind = kind;
    x.data = kind[2] ? {d, 32'h0} : {32'h0, d};
    x.err  = e;
    sb.push_back(x);
  endtask

  // One cycle: sample completions on the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (ifu_rvalid | lsu_rvalid | lsu_bvalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 64'({ifu_rvalid, lsu_rvalid, lsu_bvalid}), 64'h0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 64'({ifu_rvalid, lsu_rvalid, lsu_bvalid}), 64'(e.kind));
        chk("pulse_data", {ifu_rdata, lsu_rdata}, e.data);
        chk("pulse_err", 64'(rsp_err), 64'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Memory side of one transaction: wait for the request, stall, accept, respond.
  task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       input logic [31:0] rdata, input int stall, output int n);
    n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(mem_req_valid), 64'h1);
    chk({tag, "_addr"},  64'(mem_req_addr),  64'(addr));
    chk({tag, "_we"},    64'(mem_req_we),    64'(we));
    chk({tag, "_wstrb"}, 64'(mem_req_wstrb), 64'(wstrb));
    chk({tag, "_wdata"}, 64'(mem_req_wdata), 64'(wdata));
    mem_req_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_valid"}, 64'(mem_req_valid), 64'h1);
      chk({tag, "_stall_addr"},  64'(mem_req_addr),  64'(addr));
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
  endtask

  initial begin
    rst = 1'b0;
    ifu_araddr = '0; ifu_arvalid = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_awaddr = '0; lsu_awvalid = 1'b0;
    lsu_wdata = '0; lsu_wstrb = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h5555aaaa;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({mem_req_valid, mem_req_we, ifu_rvalid, lsu_rvalid, lsu_bvalid, rsp_err}), 64'h0);
    chk("rst_data", {ifu_rdata, lsu_rdata}, 64'h0);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    rst = 1'b1;
    tick();

    // Simultaneous IFU/LSU reads straight after reset.
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_1000; lsu_arvalid = 1'b1;
`ifdef YSYX_ARB_RR_EN
    expect_pulse(3'b100, 32'h1111_0001, 1'b0);
    serve("tie_first", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h1111_0001, 0, waited);
    ifu_arvalid = 1'b0;
    expect_pulse(3'b010, 32'h2222_0002, 1'b0);
    serve("tie_second", 32'h8000_1000, 1'b0, 32'h0, 4'h0, 32'h2222_0002, 0, waited);
    lsu_arvalid = 1'b0;
`else
    expect_pulse(3'b010, 32'h2222_0002, 1'b0);
    serve("tie_first", 32'h8000_1000, 1'b0, 32'h0, 4'h0, 32'h2222_0002, 0, waited);
    lsu_arvalid = 1'b0;
    expect_pulse(3'b100, 32'h1111_0001, 1'b0);
    serve("tie_second", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h1111_0001, 0, waited);
    ifu_arvalid = 1'b0;
`endif
    chk("tie_done", 64'(sb.size()), 64'h0);

    // Lone IFU fetch: request at cycle 1, completion at cycle 2.
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1;
    expect_pulse(3'b100, 32'h0000_0413, 1'b0);
    serve("ifu_rd", 32'h8000_0000, 1'b0, 32'h0, 4'h0, 32'h0000_0413, 0, waited);
    ifu_arvalid = 1'b0;
    chk("ifu_rd_latency", 64'(waited), 64'h1);
    chk("ifu_rd_done", 64'(sb.size()), 64'h0);

    // LSU write.
    lsu_awaddr = 32'h8000_0010; lsu_wdata = 32'hdead_beef; lsu_wstrb = 4'hf; lsu_awvalid = 1'b1;
    expect_pulse(3'b001, 32'h0, 1'b0);
    serve("lsu_wr", 32'h8000_0010, 1'b1, 32'hdead_beef, 4'hf, 32'h0, 0, waited);
    lsu_awvalid = 1'b0;
    chk("lsu_wr_done", 64'(sb.size()), 64'h0);

    // LSU write and read together: write first.
    lsu_awaddr = 32'h8000_0020; lsu_wdata = 32'h0102_0304; lsu_wstrb = 4'h3; lsu_awvalid = 1'b1;
    lsu_araddr = 32'h8000_0024; lsu_arvalid = 1'b1;
    expect_pulse(3'b001, 32'h0, 1'b0);
    serve("wr_first", 32'h8000_0020, 1'b1, 32'h0102_0304, 4'h3, 32'h0, 0, waited);
    lsu_awvalid = 1'b0;
    expect_pulse(3'b010, 32'hcafe_f00d, 1'b0);
    serve("rd_second", 32'h8000_0024, 1'b0, 32'h0, 4'h0, 32'hcafe_f00d, 0, waited);
    lsu_arvalid = 1'b0;

    // Back-pressure: owner held while the other side waits.
    lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1;
    expect_pulse(3'b010, 32'h0000_2000, 1'b0);
    tick();
    ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
    serve("stall_lsu", 32'h8000_2000, 1'b0, 32'h0, 4'h0, 32'h0000_2000, 5, waited);
    lsu_arvalid = 1'b0;
    expect_pulse(3'b100, 32'h0000_0100, 1'b0);
    serve("stall_ifu", 32'h8000_0100, 1'b0, 32'h0, 4'h0, 32'h0000_0100, 0, waited);
    ifu_arvalid = 1'b0;

    // Timeout in RSP, late response dropped, next fetch intact.
    ifu_araddr = 32'h8000_0200; ifu_arvalid = 1'b1;
    expect_pulse(3'b100, 32'h0, 1'b1);
    tick();
    chk("tmo_rsp_req", 64'(mem_req_valid), 64'h1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_rdata = 32'hbad0_bad0;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    chk("tmo_rsp_cycle", 64'(k), 64'd15);
    ifu_arvalid = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0bad_f00d;
    tick();
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    ifu_araddr = 32'h8000_0204; ifu_arvalid = 1'b1;
    expect_pulse(3'b100, 32'h0010_0073, 1'b0);
    serve("after_orphan", 32'h8000_0204, 1'b0, 32'h0, 4'h0, 32'h0010_0073, 0, waited);
    ifu_arvalid = 1'b0;
    chk("after_orphan_done", 64'(sb.size()), 64'h0);

    // Timeout in REQ: request drops, no orphan left behind.
    lsu_araddr = 32'h8000_3000; lsu_arvalid = 1'b1;
    expect_pulse(3'b010, 32'h0, 1'b1);
    tick();
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    chk("tmo_req_cycle", 64'(k), 64'd16);
    chk("tmo_req_drop", 64'(mem_req_valid), 64'h0);
    lsu_arvalid = 1'b0;
    ifu_araddr = 32'h8000_0208; ifu_arvalid = 1'b1;
    expect_pulse(3'b100, 32'h0000_0013, 1'b0);
    serve("no_orphan", 32'h8000_0208, 1'b0, 32'h0, 4'h0, 32'h0000_0013, 0, waited);
    ifu_arvalid = 1'b0;
    chk("no_orphan_done", 64'(sb.size()), 64'h0);

    // Reset asserted mid-RSP with a response on the bus.
    ifu_araddr = 32'h8000_0300; ifu_arvalid = 1'b1;
    tick();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7777_7777;
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", 64'({mem_req_valid, mem_req_we, ifu_rvalid, lsu_rvalid, lsu_bvalid, rsp_err}), 64'h0);
    chk("mid_rst_data", {ifu_rdata, lsu_rdata}, 64'h0);
    chk("mid_rst_addr", 64'(mem_req_addr), 64'h0);
    mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; ifu_arvalid = 1'b0;
    tick();
    rst = 1'b1;
    ifu_araddr = 32'h8000_0400; ifu_arvalid = 1'b1;
    expect_pulse(3'b100, 32'h0000_0297, 1'b0);
    serve("post_rst", 32'h8000_0400, 1'b0, 32'h0, 4'h0, 32'h0000_0297, 0, waited);
    ifu_arvalid = 1'b0;
    chk("post_rst_latency", 64'(waited), 64'h1);
    tick();
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
